// File: rtl/mmio_rx_port.sv
// Memory-mapped receive port: link words go into a FIFO that the processor reads through DATA/STATUS/CTRL.
// Optional macro MMIO_RX_DROP_EN: the link is never back-pressured and words that arrive while the FIFO is full are dropped.
module mmio_rx_port #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address_rw,
  input  logic [15:0] data_in,
  input  logic        memory_write_enable,
  output logic [15:0] data_out,
  output logic        sel,
  input  logic [15:0] link_data,
  input  logic        link_valid,
  output logic        link_ready,
  output logic        rx_irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_idx;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ready_en;

  logic [15:0] offset;
  logic        empty;
  logic        full;
  logic        ctrl_wr;
  logic        flush;
  logic        pop;
  logic        clr_ovf;
  logic        push;
  logic        store;
  logic        ovf_set;
  logic [15:0] status;
  logic        unused_data_bits;

  // Window offset; wraps naturally in 16 bits so the compare stays one-sided.
  assign offset = address_rw - BASE_ADDR;
  assign sel    = (offset < 16'd3);

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign rx_irq = !empty;

  // Link handshake: a word transfers on a rising edge where link_valid && link_ready.
  // ready_en stays low until the first edge after reset is released.
`ifdef MMIO_RX_DROP_EN
  assign link_ready = ready_en;
`else
  assign link_ready = ready_en && !full;
`endif

  assign ctrl_wr = memory_write_enable && (offset == 16'd2);
  assign flush   = ctrl_wr && data_in[2];
  assign pop     = ctrl_wr && data_in[0] && !empty && !flush;
  assign clr_ovf = ctrl_wr && data_in[1];
  assign push    = link_valid && link_ready;
  assign store   = push && (flush || !full || pop);
  assign wr_idx  = flush ? '0 : wr_ptr;
  assign unused_data_bits = &{1'b0, data_in[15:3]};

`ifdef MMIO_RX_DROP_EN
  assign ovf_set = push && !store;
`else
  assign ovf_set = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= store ? AW'(1) : '0;
        count  <= store ? CW'(1) : '0;
      end else begin
        if (pop)   rd_ptr <= rd_ptr + AW'(1);
        if (store) wr_ptr <= wr_ptr + AW'(1);
        count <= count + CW'(store) - CW'(pop);
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Storage needs no reset: count and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (store) mem[wr_idx] <= link_data;
  end

  assign status = {8'(count), 5'b0, overflow, full, empty};

  always_comb begin
    data_out = 16'h0000;
    case (offset)
      16'd0:   data_out = empty ? 16'h0000 : mem[rd_ptr];
      16'd1:   data_out = status;
      default: data_out = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_mmio_rx_port.sv
// Self-checking bench for mmio_rx_port: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_mmio_rx_port;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] address_rw = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic        memory_write_enable = 1'b0;
  logic [15:0] data_out;
  logic        sel;
  logic [15:0] link_data = 16'h0000;
  logic        link_valid = 1'b0;
  logic        link_ready;
  logic        rx_irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  logic        m_ovf = 1'b0;
  logic        m_ready = 1'b0;

  mmio_rx_port #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .address_rw(address_rw),
    .data_in(data_in),
    .memory_write_enable(memory_write_enable),
    .data_out(data_out),
    .sel(sel),
    .link_data(link_data),
    .link_valid(link_valid),
    .link_ready(link_ready),
    .rx_irq(rx_irq)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic model_ready();
`ifdef MMIO_RX_DROP_EN
    return m_ready;
`else
    return m_ready && (exp_q.size() < DEPTH);
`endif
  endfunction

  function automatic logic [15:0] model_status();
    logic [7:0] n;
    n = 8'(exp_q.size());
    return {n, 5'b0, m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0};
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] addr);
    logic [15:0] off;
    off = addr - BASE;
    if (off == 16'd0) return (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
    if (off == 16'd1) return model_status();
    return 16'h0000;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
        m_ovf = 1'b0;
        m_ready = 1'b0;
      end else begin
        logic accept, ctrl, was_full, did_pop, lost;
        accept = link_valid && model_ready();
        ctrl = memory_write_enable && (address_rw == BASE + 16'd2);
        lost = 1'b0;
        if (ctrl && data_in[2]) begin
          exp_q.delete();
          if (accept) exp_q.push_back(link_data);
        end else begin
          was_full = (exp_q.size() == DEPTH);
          did_pop = ctrl && data_in[0] && (exp_q.size() > 0);
          if (did_pop) void'(exp_q.pop_front());
          if (accept) begin
            if (!was_full || did_pop) exp_q.push_back(link_data);
            else lost = 1'b1;
          end
        end
        if (lost) m_ovf = 1'b1;
        else if (ctrl && data_in[1]) m_ovf = 1'b0;
        m_ready = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, 3 time units after inputs change and 2 before the rising edge
  initial begin
    forever begin
      @(negedge clk);
      #3;
      check("cmp_data_out", data_out, model_read(address_rw));
      check("cmp_sel", 16'(sel), 16'((address_rw - BASE) < 16'd3));
      check("cmp_link_ready", 16'(link_ready), 16'(model_ready()));
      check("cmp_rx_irq", 16'(rx_irq), 16'(exp_q.size() > 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [15:0] addr, input logic we, input logic [15:0] din,
                       input logic lv, input logic [15:0] ld);
    @(negedge clk);
    address_rw = addr;
    memory_write_enable = we;
    data_in = din;
    link_valid = lv;
    link_data = ld;
  endtask

  task automatic peek(input logic [15:0] addr);
    drive(addr, 1'b0, 16'h0000, 1'b0, 16'h0000);
    #2;
  endtask

  task automatic push_w(input logic [15:0] w);
    drive(BASE, 1'b0, 16'h0000, 1'b1, w);
  endtask

  task automatic ctrl_w(input logic [15:0] v);
    drive(BASE + 16'd2, 1'b1, v, 1'b0, 16'h0000);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    // Reset state while held in reset
    address_rw = BASE + 16'd1;
    #2;
    check("rst_status", data_out, 16'h0001);
    check("rst_link_ready", 16'(link_ready), 16'h0000);
    check("rst_irq", 16'(rx_irq), 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #2;
    check("release_ready_low", 16'(link_ready), 16'h0000);
    peek(BASE + 16'd1);
    check("ready_after_edge", 16'(link_ready), 16'h0001);

    // Single push
    push_w(16'hA5A5);
    peek(BASE);
    check("push_data", data_out, 16'hA5A5);
    check("push_irq", 16'(rx_irq), 16'h0001);
    peek(BASE + 16'd1);
    check("push_status", data_out, 16'h0100);
    ctrl_w(16'h0001);
    peek(BASE + 16'd1);
    check("pop_one_status", data_out, 16'h0001);

    // Fill to full
    for (int i = 0; i < DEPTH; i++) push_w(16'h4000 + 16'(i));
    peek(BASE + 16'd1);
    check("full_status", data_out, 16'h0802);
`ifdef MMIO_RX_DROP_EN
    check("full_ready_drop", 16'(link_ready), 16'h0001);
    push_w(16'hBEEF);
    peek(BASE + 16'd1);
    check("drop_status", data_out, 16'h0806);
    peek(BASE);
    check("drop_head", data_out, 16'h4000);
    ctrl_w(16'h0002);
    peek(BASE + 16'd1);
    check("clr_ovf_status", data_out, 16'h0802);
`else
    check("full_ready", 16'(link_ready), 16'h0000);
    push_w(16'hBEEF);
    peek(BASE + 16'd1);
    check("full_blocked", data_out, 16'h0802);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      peek(BASE);
      check("drain_order", data_out, 16'h4000 + 16'(i));
      ctrl_w(16'h0001);
    end
    peek(BASE + 16'd1);
    check("drained_status", data_out, 16'h0001);
    check("drained_irq", 16'(rx_irq), 16'h0000);
    ctrl_w(16'h0001);
    peek(BASE + 16'd1);
    check("pop_empty", data_out, 16'h0001);

    // Push/pop pairs across pointer wrap with 3 words resident
    for (int i = 0; i < 3; i++) push_w(16'h3000 + 16'(i));
    for (int j = 0; j < 20; j++) begin
      peek(BASE);
      check("wrap_head", data_out, 16'h3000 + 16'(j));
      drive(BASE + 16'd2, 1'b1, 16'h0001, 1'b1, 16'h3003 + 16'(j));
    end
    peek(BASE + 16'd1);
    check("wrap_status", data_out, 16'h0300);

    // Pop+flush with a same-cycle push
    drive(BASE + 16'd2, 1'b1, 16'h0005, 1'b1, 16'h1234);
    peek(BASE + 16'd1);
    check("flush_push_status", data_out, 16'h0100);
    peek(BASE);
    check("flush_push_data", data_out, 16'h1234);

    // Writes outside CTRL are ignored
    push_w(16'h5555);
    drive(BASE, 1'b1, 16'h0007, 1'b0, 16'h0000);
    drive(BASE + 16'd1, 1'b1, 16'h0007, 1'b0, 16'h0000);
    drive(BASE + 16'd3, 1'b1, 16'h0007, 1'b0, 16'h0000);
    drive(16'h0002, 1'b1, 16'h0007, 1'b0, 16'h0000);
    peek(BASE + 16'd1);
    check("ignored_writes", data_out, 16'h0200);
    peek(BASE + 16'd3);
    check("outside_sel", 16'(sel), 16'h0000);
    check("outside_data", data_out, 16'h0000);
    peek(BASE + 16'd2);
    check("ctrl_read_zero", data_out, 16'h0000);
    ctrl_w(16'h0004);

    // Reset mid-stream with 5 words held and a handshake in flight
    for (int i = 0; i < 5; i++) push_w(16'h6000 + 16'(i));
    @(negedge clk);
    rst = 1'b0;
    address_rw = BASE + 16'd1;
    memory_write_enable = 1'b0;
    link_valid = 1'b1;
    link_data = 16'h7777;
    #2;
    check("midrst_status", data_out, 16'h0001);
    check("midrst_ready", 16'(link_ready), 16'h0000);
    check("midrst_irq", 16'(rx_irq), 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    link_valid = 1'b0;
    #2;
    check("midrst_release_ready", 16'(link_ready), 16'h0000);
    peek(BASE + 16'd1);
    check("midrst_ready_up", 16'(link_ready), 16'h0001);
    check("midrst_after_status", data_out, 16'h0001);

    // Randomized traffic checked by the per-cycle compare
    for (int n = 0; n < 800; n++) begin
      logic [15:0] addr, din;
      int pick;
      pick = $urandom_range(0, 7);
      if (pick < 6) addr = BASE + 16'(pick % 4);
      else addr = 16'($urandom);
      din = 16'($urandom);
      if ($urandom_range(0, 15) != 0) din[2] = 1'b0;
      drive(addr, $urandom_range(0, 2) == 0, din, $urandom_range(0, 2) != 0, 16'($urandom));
    end
    peek(BASE + 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_rx_port.md
MMIO_RX_PORT -- requirements
Module: mmio_rx_port

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF00: base of the 3-word register window on the processor data bus.
REQ-002 SHALL have parameter DEPTH, default 8: receive FIFO depth in 16-bit words; power of 2, 2..128.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port address_rw  input  16  processor data-bus address.
REQ-006 SHALL have port data_in  input  16  processor write data.
REQ-007 SHALL have port memory_write_enable  input  1  processor write strobe.
REQ-008 SHALL have port data_out  output  16  register read data.
REQ-009 SHALL have port sel  output  1  high when address_rw is inside the window; the top level muxes data_out against data memory on it.
REQ-010 SHALL have port link_data  input  16  word from the interconnect receiver.
REQ-011 SHALL have port link_valid  input  1  link_data holds a word.
REQ-012 SHALL have port link_ready  output  1  port accepts a word this cycle.
REQ-013 SHALL have port rx_irq  output  1  level interrupt: FIFO not empty.

Function
REQ-014 SHALL decode registers as follows: BASE+0 = DATA (read-only), BASE+1 = STATUS (read-only), BASE+2 = CTRL (write-only; reads return 0).
REQ-015 SHALL drive DATA reads with the FIFO head word, or 16'h0000 when empty; a read SHALL NOT pop.
REQ-016 SHALL format STATUS as: [0] empty, [1] full, [2] overflow (sticky), [7:3] 0, [15:8] count (zero-extended).
REQ-017 SHALL make data_out and sel combinational from address_rw and registered state, with data_out = 0 when sel = 0.
REQ-018 SHALL decode CTRL writes (memory_write_enable=1 at BASE+2, captured on the clock edge) as: bit0 pop, bit1 clear overflow, bit2 flush; other bits are ignored.
REQ-019 SHALL complete a push when link_valid && link_ready at a clock edge; the word is visible at DATA on the next cycle if the FIFO was empty.
REQ-020 SHALL ignore a pop when the FIFO is empty (no underflow, count stays 0).
REQ-021 SHALL leave count unchanged on a simultaneous push and pop with the FIFO non-empty; head advances and the new word is written at the tail.
REQ-022 SHALL give flush priority over pop: it empties the FIFO; a push in the same cycle SHALL be stored as the only entry (count=1).
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count has width clog2(DEPTH)+1 and SHALL never exceed DEPTH.
REQ-024 SHALL apply clear-overflow and a same-cycle overflow set with set winning.
REQ-025 SHALL ignore writes to BASE+0, BASE+1, and all addresses outside the window.

Reset
REQ-026 SHALL, while rst=0, immediately force: pointers and count = 0, overflow = 0, empty = 1, rx_irq = 0, link_ready = 0.
REQ-027 SHALL discard FIFO contents and any in-flight handshake on reset mid-operation.
REQ-028 SHALL raise link_ready no earlier than the first clock edge after rst deasserts.

Configuration
REQ-029 SHALL support macro MMIO_RX_DROP_EN.
- Undefined: link_ready = !full (backpressure); overflow never sets.
- Defined: link_ready = 1 out of reset; a word arriving while full with no same-cycle pop SHALL be dropped and overflow set. A same-cycle pop frees a slot, so the word is stored.

Verification
REQ-030 SHALL cover: reset, push 16'hA5A5 -> next cycle DATA=16'hA5A5, STATUS=16'h0100, rx_irq=1.
REQ-031 SHALL cover: 8 pushes with DEPTH=8 -> STATUS=16'h0802, link_ready=0 (macro off); 8 pops -> STATUS=16'h0001, rx_irq=0.
REQ-032 SHALL cover: 20 push/pop pairs over pointer wrap with 3 resident words -> count stays 3 and words emerge in order.
REQ-033 SHALL cover: CTRL=16'h0005 (pop+flush) with a same-cycle push of 16'h1234 -> count=1, DATA=16'h1234.
REQ-034 SHALL cover: MMIO_RX_DROP_EN, full FIFO, push 16'hBEEF -> word dropped, STATUS bit2=1; CTRL=16'h0002 -> bit2=0.
REQ-035 SHALL cover: rst pulsed low mid-stream with 5 words held -> STATUS=16'h0001 immediately, link_ready=0 until the first edge after release.
